mem_programmer_ctrl: RTL and testbench
======================================

Name: mem_programmer_ctrl

Overview:
Parametrised, single-clock successor to the board-level memory programmer. It turns a raw push button into one debounced step event per press, and converts each event into a write or read of program memory at an auto-incrementing address. It also provides address preload, a running checksum and a wrap flag. It sits between the board I/O (buttons, switches, 7-seg data path) and the memory port that is muxed in program mode.

Parameters:
ADRS_W, 8, address width; address space is 2^ADRS_W words.
DATA_W, 8, memory word width.
DEBOUNCE_CYC, 16, consecutive stable clock cycles required before a new button level is accepted (must be >= 1).

Ports:
clock  input  1  system clock; all logic is on its rising edge
reset_N  input  1  synchronous reset, active low
step_n  input  1  raw push button, low = pressed, asynchronous to clock
mode_wr  input  1  1 = a step writes memory, 0 = a step reads memory
load_adrs  input  1  single-cycle request to preload the address from code_in
code_in  input  DATA_W  slide-switch code value
mm_q  input  DATA_W  memory read data, valid 1 cycle after the address is presented (synchronous RAM)
pr_adrs  output  ADRS_W  memory address (registered)
pr_code  output  DATA_W  write data (registered)
pr_wr_en  output  1  write strobe, one clock wide
data  output  DATA_W  last byte read or written, for the 7-seg display
checksum  output  DATA_W  modulo-2^DATA_W sum of all bytes transferred since reset or load
wrapped  output  1  sticky flag: the address has wrapped from max to 0
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset, while reset_N = 0 at a clock edge:
  - pr_adrs, pr_code, data, checksum = 0; wrapped = 0; FSM = IDLE (busy = 0).
  - Synchroniser flops and debounced level = 1 (released); debounce counter = 0.
  - pr_wr_en is forced to 0 during any cycle in which reset_N = 0, including a reset that lands in WR. An aborted operation has no further effect.
- Input conditioning:
  - step_n passes through a 2-flop synchroniser.
  - The counter counts cycles in which the synchronised value differs from the debounced level, and clears whenever they match.
  - When the counter reaches DEBOUNCE_CYC, the debounced level takes the new value and the counter clears.
  - ev is a one-cycle pulse on a debounced 1->0 transition. Release produces no event.
- FSM states: IDLE, WR, RD1, RD2, INC.
  - IDLE, ev = 1: code_reg <= code_in and pr_code <= code_in; go to WR if mode_wr = 1, else RD1.
  - IDLE, ev = 0, load_adrs = 1: pr_adrs <= code_in[ADRS_W-1:0] (zero-extend if DATA_W < ADRS_W); checksum <= 0; wrapped <= 0. Stay in IDLE.
  - IDLE, ev = 1 and load_adrs = 1 in the same cycle: the step wins and the load is ignored.
  - WR: pr_wr_en = 1 (decoded from state & reset_N); data <= code_reg; checksum <= checksum + code_reg; go to INC.
  - RD1: the address is held, and memory samples it at the end of this cycle; go to RD2.
  - RD2: data <= mm_q; checksum <= checksum + mm_q; go to INC.
  - INC: pr_adrs <= pr_adrs + 1, wrapping modulo 2^ADRS_W. If pr_adrs was all-ones, wrapped <= 1. Go to IDLE.
- Latency from ev:
  - Write: WR at +1, address updated at the end of +2.
  - Read: data valid after +3, address updated at the end of +3.
- ev or load_adrs arriving while busy = 1 is dropped (not queued).
- mode_wr and code_in are sampled only in IDLE on ev; changes mid-operation are ignored.
- Arithmetic is unsigned; checksum overflow is discarded silently.

Test Plan:
(all with DEBOUNCE_CYC=4, ADRS_W=DATA_W=8)
1. Hold reset_N=0 for 3 cycles, then release -> every output is 0, busy=0, and pr_wr_en never rises.
2. mode_wr=1, code_in=A5, step_n held low for 10 cycles then released -> exactly one pr_wr_en pulse with pr_adrs=00 and pr_code=A5; afterwards pr_adrs=01, data=A5, checksum=A5.
3. step_n toggled every 2 cycles for 12 cycles, then held low -> exactly one event and one write; the release after it produces no event.
4. Memory preloaded with [10]=3C. load_adrs with code_in=10, then mode_wr=0 and one press -> data=3C three cycles after ev, pr_adrs=11, checksum=3C, no pr_wr_en.
5. Load FF, then write 02 -> pr_adrs=00, wrapped=1, checksum=02. A second write of FF -> checksum=01, proving modulo arithmetic. A subsequent load clears wrapped and checksum.
6. Pull reset_N low in the same cycle the FSM is in WR -> pr_wr_en stays 0 and the memory location is unchanged. After reset, pr_adrs=00 and FSM=IDLE.

Source files
------------

// File: rtl/mem_programmer_ctrl_if.sv
// Memory port between the programmer controller and the muxed program RAM.
// The controller is the master: it drives address, write data and strobe,
// and the synchronous RAM returns read data one cycle after the address.
interface mem_programmer_ctrl_if #(
  parameter int ADRS_W = 8,
  parameter int DATA_W = 8
);
  logic [ADRS_W-1:0] pr_adrs;
  logic [DATA_W-1:0] pr_code;
  logic              pr_wr_en;
  logic [DATA_W-1:0] mm_q;

  modport master (
    output pr_adrs,
    output pr_code,
    output pr_wr_en,
    input  mm_q
  );

  modport slave (
    input  pr_adrs,
    input  pr_code,
    input  pr_wr_en,
    output mm_q
  );
endinterface

// File: rtl/mem_programmer_ctrl.sv
// Memory programmer controller: debounces a raw push button into one step
// event per press and turns each event into a write or read of program
// memory at an auto-incrementing address, with address preload, a running
// checksum of transferred bytes and a sticky address-wrap flag.
module mem_programmer_ctrl #(
  parameter int ADRS_W       = 8,
  parameter int DATA_W       = 8,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic                  clock,
  input  logic                  reset_N,
  input  logic                  step_n,
  input  logic                  mode_wr,
  input  logic                  load_adrs,
  input  logic [DATA_W-1:0]     code_in,
  mem_programmer_ctrl_if.master mem,
  output logic [DATA_W-1:0]     data,
  output logic [DATA_W-1:0]     checksum,
  output logic                  wrapped,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD1,
    RD2,
    INC
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              sync1;
  logic              sync2;
  logic              deb_level;
  logic [CNT_W-1:0]  deb_cnt;
  logic              ev;
  logic [DATA_W-1:0] code_reg;
  logic              wr_en;

  // Synchronise the button, debounce it and emit one event per press
  always_ff @(posedge clock) begin
    if (!reset_N) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      deb_level <= 1'b1;
      deb_cnt   <= '0;
      ev        <= 1'b0;
    end else begin
      sync1 <= step_n;
      sync2 <= sync1;
      ev    <= 1'b0;
      if (sync2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        deb_level <= sync2;
        deb_cnt   <= '0;
        ev        <= ~sync2;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end
  end

  // State register for the transfer sequencer
  always_ff @(posedge clock) begin
    if (!reset_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the strobe and busy outputs; the strobe is gated
  // by reset so an operation aborted in WR never reaches memory
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (ev) begin
          state_next = mode_wr ? WR : RD1;
        end
      end
      WR: begin
        wr_en      = reset_N;
        state_next = INC;
      end
      RD1:     state_next = RD2;
      RD2:     state_next = INC;
      INC:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem.pr_wr_en = wr_en;

  // Datapath: capture code, load address, accumulate checksum, advance address
  always_ff @(posedge clock) begin
    if (!reset_N) begin
      mem.pr_adrs <= '0;
      mem.pr_code <= '0;
      code_reg    <= '0;
      data        <= '0;
      checksum    <= '0;
      wrapped     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ev) begin
            code_reg    <= code_in;
            mem.pr_code <= code_in;
          end else if (load_adrs) begin
            mem.pr_adrs <= ADRS_W'(code_in);
            checksum    <= '0;
            wrapped     <= 1'b0;
          end
        end
        WR: begin
          data     <= code_reg;
          checksum <= checksum + code_reg;
        end
        RD2: begin
          data     <= mem.mm_q;
          checksum <= checksum + mem.mm_q;
        end
        INC: begin
          mem.pr_adrs <= mem.pr_adrs + ADRS_W'(1);
          if (&mem.pr_adrs) begin
            wrapped <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_programmer_ctrl.sv
// Self-checking bench for mem_programmer_ctrl: directed scenarios with
// literal expectations, then randomized button/mode/load traffic checked
// every cycle against a transaction-level reference model.
module tb_mem_programmer_ctrl;

  localparam int ADRS_W = 8;
  localparam int DATA_W = 8;
  localparam int DEB    = 4;

  logic              clock = 1'b0;
  logic              reset_N;
  logic              step_n;
  logic              mode_wr;
  logic              load_adrs;
  logic [DATA_W-1:0] code_in;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] checksum;
  logic              wrapped;
  logic              busy;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  mem_programmer_ctrl_if #(.ADRS_W(ADRS_W), .DATA_W(DATA_W)) mem_bus ();

  mem_programmer_ctrl #(
    .ADRS_W(ADRS_W),
    .DATA_W(DATA_W),
    .DEBOUNCE_CYC(DEB)
  ) dut (
    .clock(clock),
    .reset_N(reset_N),
    .step_n(step_n),
    .mode_wr(mode_wr),
    .load_adrs(load_adrs),
    .code_in(code_in),
    .mem(mem_bus),
    .data(data),
    .checksum(checksum),
    .wrapped(wrapped),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Synchronous program RAM, plus a log of write strobes
  logic [7:0] ram [0:255];
  int         wr_count = 0;
  logic [7:0] last_wr_adrs = 8'h00;
  logic [7:0] last_wr_code = 8'h00;

  always @(posedge clock) begin
    if (mem_bus.pr_wr_en) begin
      ram[mem_bus.pr_adrs] <= mem_bus.pr_code;
      wr_count     <= wr_count + 1;
      last_wr_adrs <= mem_bus.pr_adrs;
      last_wr_code <= mem_bus.pr_code;
    end
    mem_bus.mm_q <= ram[mem_bus.pr_adrs];
  end

  // Reference model: button filter counted in cycles, and each accepted step
  // treated as a transfer of fixed length (write: 2 cycles, read: 3 cycles)
  // whose effects land at known ages, followed by the address bump.
  logic [7:0] ref_mem [0:255];
  bit         m_s1, m_s2, m_level, m_ev, nev;
  int         m_cnt;
  int         m_age;
  int         op_len;
  bit         m_kind_wr;
  logic [7:0] m_code, m_adrs, m_pcode, m_data, m_sum;
  bit         m_wrap;

  always @(posedge clock) begin
    if (!reset_N) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b1; m_cnt = 0; m_ev = 1'b0;
      m_age = 0; m_kind_wr = 1'b0; m_code = 8'h00;
      m_adrs = 8'h00; m_pcode = 8'h00; m_data = 8'h00; m_sum = 8'h00; m_wrap = 1'b0;
    end else begin
      if (m_age == 0) begin
        if (m_ev) begin
          m_kind_wr = mode_wr;
          m_code    = code_in;
          m_pcode   = code_in;
          m_age     = 1;
        end else if (load_adrs) begin
          m_adrs = code_in;
          m_sum  = 8'h00;
          m_wrap = 1'b0;
        end
      end else begin
        op_len = m_kind_wr ? 2 : 3;
        if (m_age == op_len) begin
          if (m_adrs == 8'hFF) m_wrap = 1'b1;
          m_adrs = m_adrs + 8'h01;
          m_age  = 0;
        end else begin
          if (m_kind_wr) begin
            m_data = m_code;
            m_sum  = m_sum + m_code;
            ref_mem[m_adrs] = m_code;
          end else if (m_age == 2) begin
            m_data = ref_mem[m_adrs];
            m_sum  = m_sum + m_data;
          end
          m_age = m_age + 1;
        end
      end
      nev = 1'b0;
      if (m_s2 != m_level) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == DEB) begin
          m_level = m_s2;
          m_cnt   = 0;
          nev     = !m_level;
        end
      end else begin
        m_cnt = 0;
      end
      m_ev = nev;
      m_s2 = m_s1;
      m_s1 = step_n;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clock) begin
    if (checking) begin
      check_output("pr_adrs",  32'(mem_bus.pr_adrs), 32'(m_adrs));
      check_output("pr_code",  32'(mem_bus.pr_code), 32'(m_pcode));
      check_output("pr_wr_en", 32'(mem_bus.pr_wr_en),
                   32'(reset_N && m_age == 1 && m_kind_wr));
      check_output("data",     32'(data),     32'(m_data));
      check_output("checksum", 32'(checksum), 32'(m_sum));
      check_output("wrapped",  32'(wrapped),  32'(m_wrap));
      check_output("busy",     32'(busy),     32'(m_age != 0));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic apply_stimulus(input logic step, input logic mode,
                                input logic ld, input logic [7:0] code);
    step_n    = step;
    mode_wr   = mode;
    load_adrs = ld;
    code_in   = code;
  endtask

  task automatic load(input logic [7:0] adrs);
    apply_stimulus(1'b1, 1'b0, 1'b1, adrs);
    tick(1);
    load_adrs = 1'b0;
    tick(1);
  endtask

  task automatic press(input logic mode, input logic [7:0] code);
    apply_stimulus(1'b0, mode, 1'b0, code);
    tick(10);
    step_n = 1'b1;
    tick(10);
  endtask

  int         wr_before;
  bit         seen;
  int         len;

  initial begin
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
    reset_N = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[8'h10] = 8'h3C;  ref_mem[8'h10] = 8'h3C;
    ram[8'h40] = 8'hC3;  ref_mem[8'h40] = 8'hC3;

    // Reset held for three cycles
    @(posedge clock);
    #1 checking = 1'b1;
    tick(2);
    reset_N = 1'b1;
    tick(2);
    check_output("reset pr_adrs",  32'(mem_bus.pr_adrs), 32'h00);
    check_output("reset pr_code",  32'(mem_bus.pr_code), 32'h00);
    check_output("reset data",     32'(data), 32'h00);
    check_output("reset checksum", 32'(checksum), 32'h00);
    check_output("reset busy",     32'(busy), 32'h0);
    check_output("reset wr_count", 32'(wr_count), 32'h0);

    // Single write of A5
    wr_before = wr_count;
    press(1'b1, 8'hA5);
    check_output("wr1 pulses",   32'(wr_count - wr_before), 32'd1);
    check_output("wr1 adrs",     32'(last_wr_adrs), 32'h00);
    check_output("wr1 code",     32'(last_wr_code), 32'hA5);
    check_output("wr1 pr_adrs",  32'(mem_bus.pr_adrs), 32'h01);
    check_output("wr1 data",     32'(data), 32'hA5);
    check_output("wr1 checksum", 32'(checksum), 32'hA5);

    // Bouncing button: fast toggles filtered out, one event on the steady press
    wr_before = wr_count;
    apply_stimulus(1'b1, 1'b1, 1'b0, 8'h5A);
    for (int i = 0; i < 6; i++) begin
      step_n = ~step_n;
      tick(2);
    end
    press(1'b1, 8'h5A);
    check_output("bounce pulses",  32'(wr_count - wr_before), 32'd1);
    check_output("bounce pr_adrs", 32'(mem_bus.pr_adrs), 32'h02);
    tick(10);
    check_output("release no ev",  32'(wr_count - wr_before), 32'd1);

    // Preload 10 and read it back
    wr_before = wr_count;
    load(8'h10);
    press(1'b0, 8'h99);
    check_output("rd data",     32'(data), 32'h3C);
    check_output("rd pr_adrs",  32'(mem_bus.pr_adrs), 32'h11);
    check_output("rd checksum", 32'(checksum), 32'h3C);
    check_output("rd no write", 32'(wr_count - wr_before), 32'd0);

    // Address wrap and modulo checksum
    load(8'hFF);
    press(1'b1, 8'h02);
    check_output("wrap pr_adrs",   32'(mem_bus.pr_adrs), 32'h00);
    check_output("wrap flag",      32'(wrapped), 32'h1);
    check_output("wrap checksum",  32'(checksum), 32'h02);
    press(1'b1, 8'hFF);
    check_output("modulo checksum", 32'(checksum), 32'h01);
    load(8'h00);
    check_output("load clr wrap",  32'(wrapped), 32'h0);
    check_output("load clr sum",   32'(checksum), 32'h00);

    // Reset landing in WR aborts the write
    load(8'h40);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h77);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick(1);
      if (m_age == 1 && m_kind_wr) seen = 1'b1;
    end
    check_output("reach WR", 32'(seen), 32'h1);
    reset_N = 1'b0;
    step_n  = 1'b1;
    #1;
    check_output("abort wr_en", 32'(mem_bus.pr_wr_en), 32'h0);
    tick(2);
    reset_N = 1'b1;
    tick(2);
    check_output("abort mem",     32'(ram[8'h40]), 32'hC3);
    check_output("abort pr_adrs", 32'(mem_bus.pr_adrs), 32'h00);
    check_output("abort busy",    32'(busy), 32'h0);

    // Randomized traffic, including loads and steps while busy
    for (int seg = 0; seg < 160; seg++) begin
      mode_wr = 1'($urandom_range(0, 1));
      code_in = 8'($urandom);
      step_n  = ~step_n;
      len     = $urandom_range(1, 10);
      for (int c = 0; c < len; c++) begin
        load_adrs = ($urandom_range(0, 9) == 0);
        tick(1);
      end
      load_adrs = 1'b0;
    end
    step_n = 1'b1;
    tick(20);
    for (int i = 0; i < 256; i++) begin
      check_output("final ram", 32'(ram[i]), 32'(ref_mem[i]));
    end

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
